sub_bytes_engine: RTL and testbench
===================================

// Module: sub_bytes_engine
// PURPOSE
//  Multi-cycle AES SubBytes / InvSubBytes engine for one state word of NUM_BYTES bytes.
//  Substitutes LANES bytes per clock, using LANES forward plus LANES inverse S-box tables (FIPS-197), built in.
//  mode selects the direction for each transaction. Valid/ready on both sides; sits between AddRoundKey and ShiftRows in the round datapath.
// PARAMETERS
//  NUM_BYTES  16  bytes per transaction; must be a multiple of LANES
//  LANES      4   bytes substituted per cycle (1,2,4,8,16); STEPS = NUM_BYTES/LANES
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous reset, active-low
//  in_valid   in   1              input word valid
//  in_ready   out  1              engine can accept a word
//  mode       in   1              0 = forward S-box, 1 = inverse S-box; sampled on accept
//  data_in    in   8*NUM_BYTES    byte i = data_in[8*i+7:8*i]
//  out_valid  out  1              data_out holds a complete result
//  out_ready  in   1              consumer accepts result
//  data_out   out  8*NUM_BYTES    substituted word, same byte order
//  busy       out  1              high in S_RUN or S_DONE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=S_IDLE; in_ready=1, out_valid=0, busy=0, data_out=0, step counter=0.
//   Reset mid-transaction discards all work. No output pulse follows.
//  FSM:
//   S_IDLE: in_ready=1. On in_valid&in_ready: latch data_in into a work register and latch mode.
//    Set step=0 and go to S_RUN.
//   S_RUN: in_ready=0. Each cycle, replace work bytes [step*LANES +: LANES] with their table lookup
//    for the latched mode, then step++. On the cycle with step==STEPS-1: the final write completes,
//    data_out is loaded with the complete result, and state goes to S_DONE.
//   S_DONE: out_valid=1 and data_out is stable. On out_ready: out_valid drops next cycle, state goes to S_IDLE.
//  Latency: the accept edge plus STEPS edges make out_valid high; default is 4 cycles after accept.
//  in_ready is low in S_RUN and S_DONE. No new word is accepted until the result is taken.
//   Peak throughput is 1 word per STEPS+2 cycles.
//  mode or data_in changing after accept has no effect on the word in flight.
//  out_ready asserted before out_valid is ignored. out_valid held with out_ready=0 keeps data_out frozen indefinitely.
//  Step counter width is max(1,$clog2(STEPS)). With LANES==NUM_BYTES, S_RUN lasts exactly one cycle.
//  Both tables are purely combinational on the current slice. Only the latched mode selects the output.
//  Bytes not yet processed stay unmodified in the work register. data_out changes only on the S_RUN->S_DONE edge.
// TESTING
//  1 Reset check: hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, busy=0, data_out=0.
//  2 Forward: mode=0, data_in bytes 0..15 = 00,01,02,03,53,... -> out bytes 63,7c,77,7b,ed,...
//    out_valid rises exactly 4 cycles after accept.
//  3 Inverse and round-trip: mode=1 on data_out of test 2 -> the original bytes come back.
//    Also mode=1, all bytes 00 -> all bytes 52; byte 09 -> 40.
//  4 Backpressure: hold out_ready=0 for 10 cycles -> data_out stable, in_ready=0, in_valid ignored.
//    Release out_ready -> next word accepted in the following cycle.
//  5 Reset mid-op: drop rst_n in S_RUN at step 2 -> next cycle S_IDLE, out_valid never rises.
//    The next transaction gives correct results.
//  6 Parameter sweep: LANES=1,16 with NUM_BYTES=16 -> latency 16 and 1 cycles respectively.
//    Random words checked against a table model, 1000 transactions per config, random mode and stalls.

Source files
------------

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: multi-cycle AES SubBytes/InvSubBytes over one state word, LANES bytes per clock.
module sub_bytes_engine #(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic                   busy
);
    localparam int STEPS = NUM_BYTES / LANES;
    localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state, state_nx;
    logic [SW-1:0]            step;
    logic                     mode_q;
    logic [8*NUM_BYTES-1:0]   work, work_nx;
    logic [8*LANES-1:0]       slice_in, slice_out;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // GF(2^8) inverse as a^254; zero maps to zero naturally
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, t;
        r = 8'h01;
        t = a;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    assign slice_in = work[8*LANES*step +: 8*LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign slice_out[8*g +: 8] = mode_q ? inv_sbox(slice_in[8*g +: 8]) : sbox(slice_in[8*g +: 8]);
    end

    always_comb begin
        work_nx = work;
        work_nx[8*LANES*step +: 8*LANES] = slice_out;
    end

    always_comb begin
        in_ready  = state == S_IDLE;
        out_valid = state == S_DONE;
        busy      = state != S_IDLE;
        state_nx  = state == S_IDLE ? (in_valid ? S_RUN : S_IDLE) :
                    state == S_RUN  ? (step == LAST ? S_DONE : S_RUN) :
                    (out_ready ? S_IDLE : S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            step     <= '0;
            mode_q   <= 1'b0;
            work     <= '0;
            data_out <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && in_valid) begin
                work   <= data_in;
                mode_q <= mode;
                step   <= '0;
            end
            if (state == S_RUN) begin
                work <= work_nx;
                step <= step + SW'(1);
                if (step == LAST) data_out <= work_nx;
            end
        end
    end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: directed and random checks of sub_bytes_engine at LANES=4, 16 and 1.
module tb_sub_bytes_engine;
    localparam logic [7:0] FWD [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    localparam int STEPS [3] = '{4, 16, 1};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     iv = '0, md = '0, ordy = '0;
    wire  [2:0]     ir, ov, bz;
    logic [127:0]   din [3];
    wire  [127:0]   dout [3];
    logic [127:0]   sb [$];
    int             checks = 0, errors = 0;

    always #5 clk = ~clk;

    sub_bytes_engine #(.NUM_BYTES(16), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .mode(md[0]), .data_in(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]), .busy(bz[0]));
    sub_bytes_engine #(.NUM_BYTES(16), .LANES(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .mode(md[1]), .data_in(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]), .busy(bz[1]));
    sub_bytes_engine #(.NUM_BYTES(16), .LANES(16)) dut_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .mode(md[2]), .data_in(din[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout[2]), .busy(bz[2]));

    function automatic logic [7:0] inv_lookup(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 0; j < 256; j++) if (FWD[j] == b) r = 8'(j);
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] w, input logic m);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? inv_lookup(w[8*i +: 8]) : FWD[w[8*i +: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full handshake on instance k; got returns the word the DUT delivered
    task automatic xact(input int k, input logic [127:0] w, input logic m, input int stall,
                        output logic [127:0] got);
        int t, lat;
        logic [127:0] exp;
        t = 0;
        while (!ir[k] && t < 50) begin tick(); t++; end
        chk("ready_before_accept", 128'(ir[k]), 128'(1));
        din[k] = w; md[k] = m; iv[k] = 1'b1;
        tick();
        sb.push_back(model(w, m));
        iv[k] = 1'b0; md[k] = ~m; din[k] = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!ov[k] && lat < 40) begin tick(); lat++; end
        chk("latency", 128'(lat), 128'(STEPS[k]));
        got = dout[k];
        for (int i = 0; i < stall; i++) begin
            iv[k] = 1'b1;
            tick();
            chk("hold_data", dout[k], got);
            chk("hold_in_ready", 128'(ir[k]), 128'(0));
            chk("hold_out_valid", 128'(ov[k]), 128'(1));
        end
        iv[k] = 1'b0; ordy[k] = 1'b1;
        tick();
        ordy[k] = 1'b0;
        exp = sb.pop_front();
        chk("data", got, exp);
        chk("valid_drop", 128'(ov[k]), 128'(0));
        chk("ready_back", 128'(ir[k]), 128'(1));
    endtask

    initial begin
        logic [127:0] w, got, fwd_out;
        int quiet;
        for (int k = 0; k < 3; k++) din[k] = '0;
        // reset
        tick(); tick();
        chk("rst_in_ready", 128'(ir[0]), 128'(1));
        chk("rst_out_valid", 128'(ov[0]), 128'(0));
        chk("rst_busy", 128'(bz[0]), 128'(0));
        chk("rst_data_out", dout[0], 128'(0));
        rst_n = 1'b1;
        tick();
        // forward
        w = 128'hff_a0_90_80_70_60_50_40_30_20_10_53_03_02_01_00;
        xact(0, w, 1'b0, 0, fwd_out);
        chk("fwd_first_bytes", 128'(fwd_out[39:0]), 128'h00_ed_7b_77_7c_63);
        // inverse round-trip and known inverse values
        xact(0, fwd_out, 1'b1, 0, got);
        chk("round_trip", got, w);
        xact(0, 128'h0, 1'b1, 0, got);
        chk("inv_zero", got, {16{8'h52}});
        xact(0, 128'h09, 1'b1, 0, got);
        chk("inv_09", got, {{15{8'h52}}, 8'h40});
        // backpressure then immediate next accept
        xact(0, 128'h0123456789abcdef_fedcba9876543210, 1'b0, 10, got);
        xact(0, 128'hdeadbeef_cafef00d_12345678_9abcdef0, 1'b1, 0, got);
        // reset while in S_RUN at step 2
        din[0] = 128'h1111; md[0] = 1'b0; iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick(); tick();
        chk("mid_busy", 128'(bz[0]), 128'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 128'(ir[0]), 128'(1));
        chk("mid_rst_busy", 128'(bz[0]), 128'(0));
        chk("mid_rst_data_out", dout[0], 128'(0));
        quiet = 0;
        for (int i = 0; i < 8; i++) begin tick(); quiet += int'(ov[0]); end
        chk("mid_rst_no_valid", 128'(quiet), 128'(0));
        xact(0, w, 1'b0, 1, got);
        // random sweep on each configuration
        for (int k = 0; k < 3; k++)
            for (int n = 0; n < (k == 0 ? 200 : 1000); n++)
                xact(k, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), got);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
